keypad_scanner: RTL and testbench

Time-multiplexed 4x4 hex keypad scanner on a Pmod header; input-side counterpart of the 4-digit display multiplexer. Drives one active-low column strobe at a time, samples active-low rows, debounces across full scans, and shifts each accepted hex digit into a 16-bit entry word. The entry word is fed to the processor input port and the display multiplexer.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_debounce.sv | 139 +++++++++++++
 rtl/keypad_scanner.sv | 101 ++++++++++
 tb/tb_keypad_scanner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
// Keymap is indexed by {row, col} with column 0 leftmost.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    HELD,
    RELEASE
  } kp_state_t;

  localparam logic [3:0] COL_STROBE [0:3] = '{
    4'b1110, 4'b1101, 4'b1011, 4'b0111
  };

  localparam logic [3:0] KEYMAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debounce FSM: accepts a key after DEBOUNCE_SCANS identical scans.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_done,
  input  logic       scan_hit,
  input  logic [3:0] scan_code,
  output logic       accept,
  output logic [3:0] accept_code
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEBOUNCE_SCANS);

  kp_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       cand, cand_n;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);

  logic [REP_W-1:0] rep, rep_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep <= '0;
    else     rep <= rep_n;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  // The FSM only moves on a completed scan; between scans everything holds.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n   = rep;
`endif
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (scan_hit) begin
            cand_n = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              accept  = 1'b1;
              state_n = HELD;
              cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_n   = '0;
`endif
            end else begin
              state_n = CONFIRM;
              cnt_n   = CNT_ONE;
            end
          end
        end
        CONFIRM: begin
          if (!scan_hit) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (scan_code != cand) begin
            cand_n = scan_code;
            cnt_n  = CNT_ONE;
          end else if (cnt + CNT_ONE == DEB_N) begin
            accept  = 1'b1;
            state_n = HELD;
            cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n   = '0;
`endif
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!scan_hit) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n = '0;
`endif
            if (DEBOUNCE_SCANS == 1) begin
              state_n = IDLE;
              cnt_n   = '0;
            end else begin
              state_n = RELEASE;
              cnt_n   = CNT_ONE;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep == REP_LAST) begin
            accept = 1'b1;
            rep_n  = '0;
          end else begin
            rep_n = rep + REP_ONE;
          end
`endif
        end
        RELEASE: begin
          if (scan_hit) begin
            state_n = HELD;
            cnt_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_n   = '0;
`endif
          end else if (cnt + CNT_ONE == DEB_N) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign accept_code = cand_n;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column strobing, row sampling, decode and entry word.
// Define KEYPAD_AUTOREPEAT_EN to enable auto-repeat of a held key.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 400000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  input  logic        clr,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] data
);

  localparam int SLOT_W = $clog2(SCAN_DIV + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

  logic [3:0]        row_meta, row_sync;
  logic [SLOT_W-1:0] slot;
  logic [1:0]        col_idx;
  logic [15:0]       hit_map, cur_map;
  logic              slot_end, scan_done, scan_hit;
  logic [3:0]        scan_code;
  logic              accept;
  logic [3:0]        accept_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign slot_end = (slot == SLOT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot    <= '0;
      col_idx <= 2'd0;
      col     <= COL_STROBE[0];
      hit_map <= '0;
    end else if (slot_end) begin
      slot    <= '0;
      col_idx <= col_idx + 2'd1;
      col     <= COL_STROBE[col_idx + 2'd1];
      hit_map <= scan_done ? 16'h0000 : cur_map;
    end else begin
      slot <= slot + SLOT_ONE;
    end
  end

  // Merge this column's rows into the scan map; more than one hit is ghosting.
  always_comb begin
    cur_map   = hit_map;
    scan_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      cur_map[{r[1:0], col_idx}] = ~row_sync[r];
    end
    for (int i = 0; i < 16; i++) begin
      if (cur_map[i]) scan_code = KEYMAP[i];
    end
    scan_hit  = ($countones(cur_map) == 1);
    scan_done = slot_end && (col_idx == 2'd3);
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS  (REPEAT_SCANS)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .scan_done  (scan_done),
    .scan_hit   (scan_hit),
    .scan_code  (scan_code),
    .accept     (accept),
    .accept_code(accept_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      data      <= 16'h0000;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= accept_code;
      if (clr)         data <= accept ? {12'h000, accept_code} : 16'h0000;
      else if (accept) data <= {data[11:0], accept_code};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with a scan-level run-length model.
// Expectations adapt to KEYPAD_AUTOREPEAT_EN when that macro is defined.
module tb_keypad_scanner;

  localparam int SD   = 4;
  localparam int DEB  = 2;
  localparam int REP  = 3;
  localparam int SCAN = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data;

  logic [15:0] pressed = 16'h0000;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  int          cyc = 0;
  bit          armed = 1'b1;
  int          run = 0;
  int          none_run = 0;
  int          rep = 0;
  bit          prev_key = 1'b0;
  logic [3:0]  prev_code = 4'h0;
  logic [3:0]  acc_code = 4'h0;
  logic [3:0]  exp_col = 4'b1110;
  logic        exp_kv = 1'b0;
  logic [3:0]  exp_code = 4'h0;
  logic [15:0] exp_data = 16'h0000;

  keypad_scanner #(
    .SCAN_DIV      (SD),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .clr      (clr),
    .col      (col),
    .key_valid(key_valid),
    .key_code (key_code),
    .data     (data)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] code_at(input int p);
    case (p)
      0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
      4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
      8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
      12: return 4'h0; 13: return 4'hF; 14: return 4'hE; default: return 4'hD;
    endcase
  endfunction

  function automatic logic [15:0] mask(input logic [3:0] c);
    logic [15:0] m;
    m = 16'h0000;
    for (int p = 0; p < 16; p++) if (code_at(p) == c) m[p] = 1'b1;
    return m;
  endfunction

  // Physical keypad: a pressed key shorts its row to the strobed column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (pressed[r*4+c]) row[r] = 1'b0;
  end

  task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: scans are whole units; a press is a run of DEB identical KEY scans
  // after the keypad has been seen idle for DEB scans (or since reset).
  always @(posedge clk or posedge rst) begin
    #1;
    if (rst) begin
      cyc = 0; armed = 1'b1; run = 0; none_run = 0; rep = 0;
      prev_key = 1'b0; prev_code = 4'h0; acc_code = 4'h0;
      exp_kv = 1'b0; exp_code = 4'h0; exp_data = 16'h0000;
    end else begin
      cyc++;
      exp_kv = 1'b0;
      if (cyc % SCAN == 0) begin
        bit         is_key;
        logic [3:0] code;
        is_key = ($countones(pressed) == 1);
        code = 4'h0;
        for (int p = 0; p < 16; p++) if (pressed[p]) code = code_at(p);
        if (is_key) begin
          run = (prev_key && prev_code == code) ? run + 1 : 1;
          none_run = 0;
          if (armed && run >= DEB) begin
            exp_kv = 1'b1; acc_code = code; armed = 1'b0; rep = 0;
          end else if (!armed && prev_key) begin
`ifdef KEYPAD_AUTOREPEAT_EN
            rep++;
            if (rep == REP) begin
              exp_kv = 1'b1; rep = 0;
            end
`endif
          end
        end else begin
          run = 0; rep = 0;
          none_run++;
          if (none_run >= DEB) armed = 1'b1;
        end
        prev_key = is_key;
        prev_code = code;
        if (exp_kv) exp_code = acc_code;
      end
      if (clr) exp_data = exp_kv ? {12'h000, acc_code} : 16'h0000;
      else if (exp_kv) exp_data = {exp_data[11:0], acc_code};
    end
    exp_col = ~(4'b0001 << ((cyc / SD) % 4));
    check_output("col", {12'h000, col}, {12'h000, exp_col});
    check_output("key_valid", {15'h0, key_valid}, {15'h0, exp_kv});
    check_output("key_code", {12'h000, key_code}, {12'h000, exp_code});
    check_output("data", data, exp_data);
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) pulses++;
  end

  task automatic apply_stimulus(input logic [15:0] keys, input int scans);
    pressed = keys;
    repeat (scans * SCAN) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] c);
    apply_stimulus(mask(c), 3);
    apply_stimulus(16'h0000, 3);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_col", {12'h000, col}, 16'h000E);
    check_output("reset_data", data, 16'h0000);
    rst = 1'b0;

    apply_stimulus(16'h0000, 4);
    check_output("idle_pulses", 16'(pulses), 16'd0);
    check_output("idle_col_wrap", {12'h000, col}, 16'h000E);

    pulses = 0;
    apply_stimulus(mask(4'h5), 4);
    apply_stimulus(16'h0000, 3);
    check_output("key5_pulses", 16'(pulses), 16'd1);
    check_output("key5_code", {12'h000, key_code}, 16'h0005);
    check_output("key5_data", data, 16'h0005);

    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'hA);
    check_output("seq_123A", data, 16'h123A);
    press_key(4'hB);
    check_output("seq_23AB", data, 16'h23AB);

    pulses = 0;
    apply_stimulus(mask(4'h5), 1);
    apply_stimulus(16'h0000, 3);
    check_output("bounce_pulses", 16'(pulses), 16'd0);

    pulses = 0;
    apply_stimulus(mask(4'h1) | mask(4'h6), 4);
    apply_stimulus(16'h0000, 3);
    check_output("ghost_pulses", 16'(pulses), 16'd0);
    check_output("ghost_data", data, 16'h23AB);

    press_key(4'h1); press_key(4'h2); press_key(4'h3); press_key(4'h4);
    check_output("seq_1234", data, 16'h1234);
    pressed = mask(4'h7);
    repeat (2 * SCAN - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    apply_stimulus(mask(4'h7), 1);
    apply_stimulus(16'h0000, 3);
    check_output("clr_accept_data", data, 16'h0007);
    check_output("clr_accept_code", {12'h000, key_code}, 16'h0007);

    apply_stimulus(mask(4'h8), 1);
    repeat (SCAN / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst_col", {12'h000, col}, 16'h000E);
    check_output("midrst_valid", {15'h0, key_valid}, 16'h0000);
    check_output("midrst_code", {12'h000, key_code}, 16'h0000);
    check_output("midrst_data", data, 16'h0000);
    repeat (3) @(negedge clk);
    pressed = 16'h0000;
    rst = 1'b0;
    apply_stimulus(16'h0000, 2);

    pulses = 0;
    apply_stimulus(mask(4'h9), 12);
    apply_stimulus(16'h0000, 3);
`ifdef KEYPAD_AUTOREPEAT_EN
    check_output("hold9_pulses", 16'(pulses), 16'd4);
    check_output("hold9_data", data, 16'h9999);
`else
    check_output("hold9_pulses", 16'(pulses), 16'd1);
    check_output("hold9_data", data, 16'h0009);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
